// File: rtl/sprite_pkg.sv
// Shared sprite types, palette and sizes.
// Imported by sprite_hit and sprite_renderer.
package sprite_pkg;

  localparam int SPR_SIZE = 16;
  localparam int TILE_MAX = 8;

  localparam logic [23:0] SPR_PALETTE [16] = '{
    24'h000000, 24'h101010, 24'hFFFFFF, 24'hE45C10,
    24'hB53120, 24'hFCBC3C, 24'hFFD800, 24'hAC7C00,
    24'h0058F8, 24'h3CBCFC, 24'h00A800, 24'h58D854,
    24'h881400, 24'hF878F8, 24'h6844FC, 24'hBCBCBC
  };

  typedef struct packed {
    logic signed [15:0]  x;
    logic signed [15:0]  y;
    logic [TILE_MAX-1:0] tile;
    logic                vis;
    logic                flip;
  } sprite_attr_t;

endpackage

// File: rtl/sprite_hit.sv
// Bounding-box test and local offsets for one slot.
// Ports: sx/sy screen pos, attr slot attributes; hit, dx, dy out.
// SPRITE_MIRROR_EN: apply horizontal mirror to dx when attr.flip.
module sprite_hit
  import sprite_pkg::*;
(
  input  logic signed [15:0] sx,
  input  logic signed [15:0] sy,
  input  sprite_attr_t       attr,
  output logic               hit,
  output logic [3:0]         dx,
  output logic [3:0]         dy
);

  logic signed [16:0] sx_w, sy_w;
  logic signed [16:0] x_lo, x_hi;
  logic signed [16:0] y_lo, y_hi;
  logic [3:0]         raw_dx;
  logic               unused_attr;

  // 17-bit so that x+15 near 32767 cannot wrap
  assign sx_w = 17'(sx);
  assign sy_w = 17'(sy);
  assign x_lo = 17'($signed(attr.x));
  assign y_lo = 17'($signed(attr.y));
  assign x_hi = x_lo + 17'sd15;
  assign y_hi = y_lo + 17'sd15;

  assign hit = attr.vis
    && (sx_w >= x_lo) && (sx_w <= x_hi)
    && (sy_w >= y_lo) && (sy_w <= y_hi);

  assign raw_dx = sx[3:0] - attr.x[3:0];
  assign dy     = sy[3:0] - attr.y[3:0];

`ifdef SPRITE_MIRROR_EN
  assign dx = attr.flip ? ~raw_dx : raw_dx;
`else
  assign dx = raw_dx;
`endif

  assign unused_attr = ^{attr.tile, attr.flip};

endmodule

// File: rtl/sprite_renderer.sv
// 3-stage sprite overlay: hit/priority, ROM address, palette mux.
// Ports: i_sx/i_sy/i_frame/i_bg_rgb, i_wr_* attrs, ROM, o_rgb/o_hit.
// SPRITE_MIRROR_EN: store i_wr_flip per slot and mirror dx.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 8,
  parameter int TILE_W  = 4
) (
  input  logic                 i_pix_clk,
  input  logic                 i_rst_n,
  input  logic signed [15:0]   i_sx,
  input  logic signed [15:0]   i_sy,
  input  logic                 i_frame,
  input  logic [23:0]          i_bg_rgb,
  input  logic                 i_wr_en,
  input  logic [3:0]           i_wr_idx,
  input  logic signed [15:0]   i_wr_x,
  input  logic signed [15:0]   i_wr_y,
  input  logic [TILE_W-1:0]    i_wr_tile,
  input  logic                 i_wr_vis,
  input  logic                 i_wr_flip,
  output logic [TILE_W+7:0]    o_rom_addr,
  input  logic [3:0]           i_rom_data,
  output logic [23:0]          o_rgb,
  output logic                 o_hit
);

  sprite_attr_t shadow [NUM_SPR];
  sprite_attr_t active [NUM_SPR];
  sprite_attr_t eff    [NUM_SPR];
  sprite_attr_t wr_attr;

  logic [NUM_SPR-1:0] hits;
  logic [3:0]         dxs [NUM_SPR];
  logic [3:0]         dys [NUM_SPR];

  logic              win_v;
  logic [3:0]        win_dx, win_dy;
  logic [TILE_W-1:0] win_tile;

  logic              v1, v2;
  logic [3:0]        dx1, dy1;
  logic [TILE_W-1:0] tile1;
  logic [23:0]       bg1, bg2;
  logic              opaque;
  logic              unused_flip;

  always_comb begin
    wr_attr      = '0;
    wr_attr.x    = i_wr_x;
    wr_attr.y    = i_wr_y;
    wr_attr.tile = TILE_MAX'(i_wr_tile);
    wr_attr.vis  = i_wr_vis;
`ifdef SPRITE_MIRROR_EN
    wr_attr.flip = i_wr_flip;
`endif
  end

  assign unused_flip = i_wr_flip;

  // active loads the pre-edge shadow; a same-cycle write waits a frame
  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_SPR; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SPR; k++) begin
        if (i_frame)
          active[k] <= shadow[k];
        if (i_wr_en && i_wr_idx == 4'(k))
          shadow[k] <= wr_attr;
      end
    end
  end

  // the pixel beside the frame pulse already sees the new scene
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_slot
    assign eff[g] = i_frame ? shadow[g] : active[g];
    sprite_hit u_hit (
      .sx   (i_sx),
      .sy   (i_sy),
      .attr (eff[g]),
      .hit  (hits[g]),
      .dx   (dxs[g]),
      .dy   (dys[g])
    );
  end

  always_comb begin
    win_v    = 1'b0;
    win_dx   = '0;
    win_dy   = '0;
    win_tile = '0;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      if (hits[k]) begin
        win_v    = 1'b1;
        win_dx   = dxs[k];
        win_dy   = dys[k];
        win_tile = eff[k].tile[TILE_W-1:0];
      end
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1    <= 1'b0;
      dx1   <= '0;
      dy1   <= '0;
      tile1 <= '0;
      bg1   <= '0;
    end else begin
      v1    <= win_v;
      dx1   <= win_dx;
      dy1   <= win_dy;
      tile1 <= win_tile;
      bg1   <= i_bg_rgb;
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_addr <= '0;
      v2         <= 1'b0;
      bg2        <= '0;
    end else begin
      o_rom_addr <= {tile1, dy1, dx1};
      v2         <= v1;
      bg2        <= bg1;
    end
  end

  assign opaque = v2 && (i_rom_data != 4'd0);

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rgb <= '0;
      o_hit <= 1'b0;
    end else begin
      o_rgb <= opaque ? SPR_PALETTE[i_rom_data] : bg2;
      o_hit <= opaque;
    end
  end

endmodule
